// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and helpers for the game sequencer / scorekeeper.
//   game_state_t : encoded game state (IDLE=0, PLAY=1, RESPAWN=2, CLEAR=3, OVER=4)
//   BCD_W        : bits per BCD digit
//   MAX_BULLETS  : widest bullet_hit vector popcount() accepts
//   popcount()   : number of set bits in a (zero-extended) hit vector
// Optional feature macro used by the files that import this package:
//   GAME_HIGH_SCORE_EN
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_RESPAWN = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_OVER    = 3'd4
  } game_state_t;

  localparam int BCD_W       = 4;
  localparam int MAX_BULLETS = 32;

  // Result is 6 bits wide: enough for a count of up to 32 set bits.
  function automatic logic [5:0] popcount(input logic [MAX_BULLETS-1:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/game_score_keeper_bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
// Multi-digit BCD up-counter that saturates at all-nines.
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset (count -> 0)
//   clr     in   synchronous clear (count -> 0), higher priority than inc
//   inc     in   add one; dropped when every digit already reads 9
//   count   out  BCD value, digit 0 in the LSBs
// With GAME_HIGH_SCORE_EN defined:
//   cmp_bcd in   BCD value to compare against
//   cmp_gt  out  count > cmp_bcd (digit-wise, most significant digit first)
// ---------------------------------------------------------------------------
module bcd_counter
  import game_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      inc,
`ifdef GAME_HIGH_SCORE_EN
  input  logic [BCD_W*DIGITS-1:0]   cmp_bcd,
  output logic                      cmp_gt,
`endif
  output logic [BCD_W*DIGITS-1:0]   count
);

  logic [DIGITS-1:0] nine;
  logic [DIGITS-1:0] carry;   // carry[gi] = digit gi must step this cycle
  logic              all_nines;

  assign all_nines = &nine;
  // Saturation: once every digit is 9 the increment is simply swallowed.
  assign carry[0]  = inc & ~all_nines;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [BCD_W-1:0] digit_reg;

      assign nine[gi] = (digit_reg == BCD_W'(9));
      assign count[gi*BCD_W +: BCD_W] = digit_reg;

      if (gi < DIGITS - 1) begin : g_chain
        assign carry[gi+1] = carry[gi] & nine[gi];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          digit_reg <= '0;
        end else if (clr) begin
          digit_reg <= '0;
        end else if (carry[gi]) begin
          // 9 wraps to 0; the carry into the next digit comes from carry[gi+1]
          digit_reg <= nine[gi] ? '0 : digit_reg + BCD_W'(1);
        end
      end
    end
  endgenerate

`ifdef GAME_HIGH_SCORE_EN
  logic decided;
  always_comb begin
    cmp_gt  = 1'b0;
    decided = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!decided && (count[i*BCD_W +: BCD_W] != cmp_bcd[i*BCD_W +: BCD_W])) begin
        cmp_gt  = (count[i*BCD_W +: BCD_W] > cmp_bcd[i*BCD_W +: BCD_W]);
        decided = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/game_score_keeper.sv
// ---------------------------------------------------------------------------
// game_score_keeper
// Game-level sequencer and scorekeeper for the VGA shooter (25 MHz pixel clk).
// Ports:
//   clk25          in   pixel clock, rising edge
//   rst_n          in   synchronous active-low reset
//   frame_tick     in   one-cycle pulse per frame
//   btn_start      in   debounced start button level (rising edge = start)
//   bullet_hit     in   per-bullet hit strobes [BULLET_COUNT]
//   player_hit     in   player/enemy collision pulse
//   wave_clear     in   level, all enemies dead
//   state          out  encoded game state (game_state_t)
//   game_active    out  high in PLAY and RESPAWN
//   score_bcd      out  BCD score, digit 0 in LSBs
//   lives          out  remaining lives
//   invuln         out  high in RESPAWN
//   enemy_respawn  out  one-cycle strobe on every entry into PLAY from IDLE/CLEAR
//   high_score_bcd out  best score seen (only with GAME_HIGH_SCORE_EN defined)
// Optional feature macro: GAME_HIGH_SCORE_EN
// BULLET_COUNT must not exceed game_pkg::MAX_BULLETS.
// ---------------------------------------------------------------------------
module game_score_keeper
  import game_pkg::*;
#(
  parameter int BULLET_COUNT  = 8,
  parameter int DIGITS        = 4,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int CLEAR_FRAMES  = 60
) (
  input  logic                     clk25,
  input  logic                     rst_n,
  input  logic                     frame_tick,
  input  logic                     btn_start,
  input  logic [BULLET_COUNT-1:0]  bullet_hit,
  input  logic                     player_hit,
  input  logic                     wave_clear,
  output logic [2:0]               state,
  output logic                     game_active,
  output logic [BCD_W*DIGITS-1:0]  score_bcd,
  output logic [2:0]               lives,
  output logic                     invuln,
`ifdef GAME_HIGH_SCORE_EN
  output logic [BCD_W*DIGITS-1:0]  high_score_bcd,
`endif
  output logic                     enemy_respawn
);

  localparam logic [2:0] START_LIVES_L = 3'(START_LIVES);
  localparam logic [7:0] INVULN_L      = 8'(INVULN_FRAMES);
  localparam logic [7:0] CLEAR_L       = 8'(CLEAR_FRAMES);
  localparam logic [5:0] PEND_MAX      = 6'd63;

  game_state_t state_reg;
  logic [2:0]  lives_reg;
  logic [7:0]  cnt_reg;          // shared frame counter for RESPAWN and CLEAR
  logic        btn_prev_reg;
  logic        game_active_reg;
  logic        invuln_reg;
  logic        respawn_reg;
  logic [5:0]  pending_reg;

  logic        start_edge;
  logic        start_play;
  logic        enter_over;
  logic        scoring;
  logic        drain;
  logic [5:0]  hit_count;
  logic [7:0]  pend_sum;
  logic [BCD_W*DIGITS-1:0] score_w;

  assign start_edge = btn_start & ~btn_prev_reg;
  assign start_play = (state_reg == ST_IDLE) && start_edge;
  assign enter_over = (state_reg == ST_PLAY) && player_hit && (lives_reg <= 3'd1);
  assign scoring    = (state_reg == ST_PLAY) || (state_reg == ST_RESPAWN) ||
                      (state_reg == ST_CLEAR);
  assign drain      = (pending_reg != 6'd0);
  assign hit_count  = popcount(MAX_BULLETS'(bullet_hit));

  // ---------------------------------------------------------------------
  // Game FSM. Output flags are updated alongside every state change so
  // they are true registers aligned with the state register.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      lives_reg       <= '0;
      cnt_reg         <= '0;
      btn_prev_reg    <= 1'b0;
      game_active_reg <= 1'b0;
      invuln_reg      <= 1'b0;
      respawn_reg     <= 1'b0;
    end else begin
      btn_prev_reg <= btn_start;
      respawn_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_edge) begin
            state_reg       <= ST_PLAY;
            lives_reg       <= START_LIVES_L;
            game_active_reg <= 1'b1;
            respawn_reg     <= 1'b1;
          end
        end
        ST_PLAY: begin
          // A collision outranks a simultaneous wave clear.
          if (player_hit) begin
            if (lives_reg <= 3'd1) begin
              state_reg       <= ST_OVER;
              lives_reg       <= '0;
              game_active_reg <= 1'b0;
            end else begin
              state_reg  <= ST_RESPAWN;
              lives_reg  <= lives_reg - 3'd1;
              cnt_reg    <= INVULN_L;
              invuln_reg <= 1'b1;
            end
          end else if (wave_clear) begin
            state_reg       <= ST_CLEAR;
            cnt_reg         <= CLEAR_L;
            game_active_reg <= 1'b0;
          end
        end
        ST_RESPAWN: begin
          if (frame_tick) begin
            cnt_reg <= (cnt_reg <= 8'd1) ? 8'd0 : cnt_reg - 8'd1;
            if (cnt_reg <= 8'd1) begin
              state_reg  <= ST_PLAY;
              invuln_reg <= 1'b0;
            end
          end
        end
        ST_CLEAR: begin
          if (frame_tick) begin
            cnt_reg <= (cnt_reg <= 8'd1) ? 8'd0 : cnt_reg - 8'd1;
            if (cnt_reg <= 8'd1) begin
              state_reg       <= ST_PLAY;
              game_active_reg <= 1'b1;
              respawn_reg     <= 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (start_edge) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg       <= ST_IDLE;
          game_active_reg <= 1'b0;
          invuln_reg      <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Pending-point accumulator: absorbs bursts of hits and feeds the BCD
  // counter one point per cycle. Add and drain share the same cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    pend_sum = {2'b00, pending_reg} - {7'd0, drain};
    if (scoring) begin
      pend_sum = pend_sum + {2'b00, hit_count};
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      pending_reg <= '0;
    end else if (start_play || enter_over) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= (pend_sum > {2'b00, PEND_MAX}) ? PEND_MAX : pend_sum[5:0];
    end
  end

`ifdef GAME_HIGH_SCORE_EN
  logic [BCD_W*DIGITS-1:0] high_reg;
  logic                    score_gt_high;
`endif

  bcd_counter #(
    .DIGITS (DIGITS)
  ) u_score (
    .clk     (clk25),
    .rst_n   (rst_n),
    .clr     (start_play),
    .inc     (drain),
`ifdef GAME_HIGH_SCORE_EN
    .cmp_bcd (high_reg),
    .cmp_gt  (score_gt_high),
`endif
    .count   (score_w)
  );

`ifdef GAME_HIGH_SCORE_EN
  // The score is frozen throughout OVER, so sampling it on the first OVER
  // cycle captures the final game score.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      high_reg <= '0;
    end else if ((state_reg == ST_OVER) && score_gt_high) begin
      high_reg <= score_w;
    end
  end
  assign high_score_bcd = high_reg;
`endif

  assign state         = state_reg;
  assign game_active   = game_active_reg;
  assign score_bcd     = score_w;
  assign lives         = lives_reg;
  assign invuln        = invuln_reg;
  assign enemy_respawn = respawn_reg;

endmodule
